// File: rtl/axis_snoop_pkg.sv
// Shared definitions for the snoop stream merge/demux pair: FSM encoding and
// header field placement used by both the arbiter (insertion) and the demux (strip).
package axis_snoop_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } demux_state_e;

    localparam int MAX_INTERFACES = 4;
    localparam int HDR_SEL_LSB    = 0;
    localparam int HDR_SEL_W      = 2;

endpackage

// File: rtl/axis_snoop_demux.sv
// Packet-atomic AXI-Stream 1->N demux. The header beat selects the destination
// port and is stripped; payload goes through a single-entry output register.
module axis_snoop_demux
    import axis_snoop_pkg::*;
#(
    parameter int NUM_INTERFACES = 2,
    parameter int PORT_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,

    input  logic [PORT_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,

    output logic [PORT_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,

    output logic [PORT_WIDTH-1:0] m01_axis_tdata,
    output logic                  m01_axis_tlast,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,

    output logic [PORT_WIDTH-1:0] m02_axis_tdata,
    output logic                  m02_axis_tlast,
    output logic                  m02_axis_tvalid,
    input  logic                  m02_axis_tready,

    output logic [PORT_WIDTH-1:0] m03_axis_tdata,
    output logic                  m03_axis_tlast,
    output logic                  m03_axis_tvalid,
    input  logic                  m03_axis_tready,

    output logic [CNT_WIDTH-1:0]  drop_count
);

    // One bit per physical port; ports at or beyond NUM_INTERFACES are never selected.
    localparam logic [MAX_INTERFACES-1:0] PORT_EN =
        MAX_INTERFACES'((1 << NUM_INTERFACES) - 1);

    demux_state_e            state_r;
    logic [HDR_SEL_W-1:0]    sel_r;
    logic [PORT_WIDTH-1:0]   out_data_r;
    logic                    out_last_r;
    logic [HDR_SEL_W-1:0]    out_dest_r;
    logic                    out_valid_r;
    logic [CNT_WIDTH-1:0]    drop_cnt_r;

    logic [HDR_SEL_W-1:0]    hdr_sel_s;
    logic                    hdr_ok_s;
    logic                    out_ready_s;
    logic                    m_hs_s;
    logic                    s_ready_s;
    logic                    s_hs_s;
    logic [MAX_INTERFACES-1:0] m_valid_s;
    logic [MAX_INTERFACES-1:0] m_last_s;
    logic [PORT_WIDTH-1:0]   m_data_s [MAX_INTERFACES];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign hdr_sel_s = s_axis_tdata[HDR_SEL_LSB +: HDR_SEL_W];
    assign hdr_ok_s  = PORT_EN[hdr_sel_s];

    // Ready of the port currently owning the held beat.
    always_comb begin
        out_ready_s = 1'b0;
        case (out_dest_r)
            2'd0:    out_ready_s = m00_axis_tready;
            2'd1:    out_ready_s = m01_axis_tready;
            2'd2:    out_ready_s = m02_axis_tready;
            2'd3:    out_ready_s = m03_axis_tready;
            default: out_ready_s = 1'b0;
        endcase
        out_ready_s = out_ready_s && PORT_EN[out_dest_r];
    end

    assign m_hs_s = out_valid_r && out_ready_s;

    // Input ready: FWD accepts whenever the output register drains this cycle.
    always_comb begin
        s_ready_s = 1'b0;
        case (state_r)
            HDR:     s_ready_s = 1'b1;
            FWD:     s_ready_s = !out_valid_r || out_ready_s;
            DROP:    s_ready_s = 1'b1;
            default: s_ready_s = 1'b0;
        endcase
        if (!axis_aresetn) begin
            s_ready_s = 1'b0;
        end else begin
            s_ready_s = s_ready_s;
        end
    end

    assign s_hs_s        = s_axis_tvalid && s_ready_s;
    assign s_axis_tready = s_ready_s;

    // Fan the output register out to the addressed port only.
    always_comb begin
        m_valid_s = '0;
        m_last_s  = '0;
        for (int i = 0; i < MAX_INTERFACES; i++) begin
            m_valid_s[i] = out_valid_r && (out_dest_r == 2'(i)) && PORT_EN[i];
            m_last_s[i]  = m_valid_s[i] && out_last_r;
            if (m_valid_s[i]) begin
                m_data_s[i] = out_data_r;
            end else begin
                m_data_s[i] = '0;
            end
        end
    end

    assign m00_axis_tvalid = m_valid_s[0];
    assign m00_axis_tlast  = m_last_s[0];
    assign m00_axis_tdata  = m_data_s[0];
    assign m01_axis_tvalid = m_valid_s[1];
    assign m01_axis_tlast  = m_last_s[1];
    assign m01_axis_tdata  = m_data_s[1];
    assign m02_axis_tvalid = m_valid_s[2];
    assign m02_axis_tlast  = m_last_s[2];
    assign m02_axis_tdata  = m_data_s[2];
    assign m03_axis_tvalid = m_valid_s[3];
    assign m03_axis_tlast  = m_last_s[3];
    assign m03_axis_tdata  = m_data_s[3];
    assign drop_count      = drop_cnt_r;

    // Packet FSM, output register and drop counter.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_r     <= HDR;
            sel_r       <= 2'd0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_dest_r  <= 2'd0;
            out_valid_r <= 1'b0;
            drop_cnt_r  <= '0;
        end else begin
            // A reload in the same cycle as a drain keeps the register full.
            if (s_hs_s && (state_r == FWD)) begin
                out_data_r  <= s_axis_tdata;
                out_last_r  <= s_axis_tlast;
                out_dest_r  <= sel_r;
                out_valid_r <= 1'b1;
            end else if (m_hs_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                HDR: begin
                    if (s_hs_s) begin
                        if (s_axis_tlast) begin
                            drop_cnt_r <= sat_inc(drop_cnt_r);
                        end else if (hdr_ok_s) begin
                            sel_r   <= hdr_sel_s;
                            state_r <= FWD;
                        end else begin
                            state_r <= DROP;
                        end
                    end
                end
                FWD: begin
                    if (s_hs_s && s_axis_tlast) begin
                        state_r <= HDR;
                    end
                end
                DROP: begin
                    if (s_hs_s && s_axis_tlast) begin
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                        state_r    <= HDR;
                    end
                end
                default: begin
                    state_r <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_snoop_demux.sv
// Directed bench for axis_snoop_demux (NUM_INTERFACES=2, 8-bit data).
module tb_axis_snoop_demux;

    logic       axis_aclk;
    logic       axis_aresetn;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tlast;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m00_axis_tdata, m01_axis_tdata, m02_axis_tdata, m03_axis_tdata;
    logic       m00_axis_tlast, m01_axis_tlast, m02_axis_tlast, m03_axis_tlast;
    logic       m00_axis_tvalid, m01_axis_tvalid, m02_axis_tvalid, m03_axis_tvalid;
    logic       m00_axis_tready, m01_axis_tready, m02_axis_tready, m03_axis_tready;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    axis_snoop_demux #(.NUM_INTERFACES(2), .PORT_WIDTH(8), .CNT_WIDTH(16)) dut (
        .axis_aclk       (axis_aclk),
        .axis_aresetn    (axis_aresetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m01_axis_tdata  (m01_axis_tdata),
        .m01_axis_tlast  (m01_axis_tlast),
        .m01_axis_tvalid (m01_axis_tvalid),
        .m01_axis_tready (m01_axis_tready),
        .m02_axis_tdata  (m02_axis_tdata),
        .m02_axis_tlast  (m02_axis_tlast),
        .m02_axis_tvalid (m02_axis_tvalid),
        .m02_axis_tready (m02_axis_tready),
        .m03_axis_tdata  (m03_axis_tdata),
        .m03_axis_tlast  (m03_axis_tlast),
        .m03_axis_tvalid (m03_axis_tvalid),
        .m03_axis_tready (m03_axis_tready),
        .drop_count      (drop_count)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // port = -1: nothing valid anywhere; otherwise only that port carries {d,l}.
    task automatic chk_out(input string tag, input int port, input logic [7:0] d, input logic l);
        logic [3:0] v_a, l_a;
        logic [7:0] d_a [4];
        v_a = {m03_axis_tvalid, m02_axis_tvalid, m01_axis_tvalid, m00_axis_tvalid};
        l_a = {m03_axis_tlast, m02_axis_tlast, m01_axis_tlast, m00_axis_tlast};
        d_a[0] = m00_axis_tdata;
        d_a[1] = m01_axis_tdata;
        d_a[2] = m02_axis_tdata;
        d_a[3] = m03_axis_tdata;
        for (int i = 0; i < 4; i++) begin
            if (i == port) begin
                chk($sformatf("%s_v%0d", tag, i), 32'(v_a[i]), 32'd1);
                chk($sformatf("%s_d%0d", tag, i), 32'(d_a[i]), 32'(d));
                chk($sformatf("%s_l%0d", tag, i), 32'(l_a[i]), 32'(l));
            end else begin
                chk($sformatf("%s_v%0d", tag, i), 32'(v_a[i]), 32'd0);
                chk($sformatf("%s_d%0d", tag, i), 32'(d_a[i]), 32'd0);
                chk($sformatf("%s_l%0d", tag, i), 32'(l_a[i]), 32'd0);
            end
        end
    endtask

    // Present one beat at a negedge, expect it accepted on the next posedge.
    task automatic drive(input string tag, input logic [7:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        #1;
        chk({tag, "_rdy"}, 32'(s_axis_tready), 32'd1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        axis_aresetn    = 1'b0;
        s_axis_tdata    = 8'h00;
        s_axis_tlast    = 1'b0;
        s_axis_tvalid   = 1'b0;
        m00_axis_tready = 1'b1;
        m01_axis_tready = 1'b1;
        m02_axis_tready = 1'b1;
        m03_axis_tready = 1'b1;

        // Reset state
        @(negedge axis_aclk);
        chk_out("rst", -1, 8'h00, 1'b0);
        chk("rst_rdy", 32'(s_axis_tready), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;

        // 1: header 01 -> m01 gets C0, C1(last)
        drive("t1_h", 8'h01, 1'b0);
        chk_out("t1_h", -1, 8'h00, 1'b0);
        drive("t1_c0", 8'hC0, 1'b0);
        chk_out("t1_c0", 1, 8'hC0, 1'b0);
        drive("t1_c1", 8'hC1, 1'b1);
        chk_out("t1_c1", 1, 8'hC1, 1'b1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk_out("t1_idle", -1, 8'h00, 1'b0);
        chk("t1_drop", 32'(drop_count), 32'd0);

        // 2: back-to-back packets, ready checked on every beat
        drive("t2_h0", 8'h00, 1'b0);
        chk_out("t2_h0", -1, 8'h00, 1'b0);
        drive("t2_a0", 8'hA0, 1'b0);
        chk_out("t2_a0", 0, 8'hA0, 1'b0);
        drive("t2_a1", 8'hA1, 1'b0);
        chk_out("t2_a1", 0, 8'hA1, 1'b0);
        drive("t2_a2", 8'hA2, 1'b1);
        chk_out("t2_a2", 0, 8'hA2, 1'b1);
        drive("t2_h1", 8'h01, 1'b0);
        chk_out("t2_h1", -1, 8'h00, 1'b0);
        drive("t2_b0", 8'hB0, 1'b1);
        chk_out("t2_b0", 1, 8'hB0, 1'b1);

        // 3: header selects unused port 3 -> whole packet dropped
        drive("t3_h", 8'h03, 1'b0);
        chk_out("t3_h", -1, 8'h00, 1'b0);
        drive("t3_x0", 8'h20, 1'b0);
        chk_out("t3_x0", -1, 8'h00, 1'b0);
        drive("t3_x1", 8'h21, 1'b0);
        chk_out("t3_x1", -1, 8'h00, 1'b0);
        drive("t3_x2", 8'h22, 1'b0);
        chk_out("t3_x2", -1, 8'h00, 1'b0);
        drive("t3_x3", 8'h23, 1'b1);
        chk_out("t3_x3", -1, 8'h00, 1'b0);
        chk("t3_drop", 32'(drop_count), 32'd1);

        // 4: backpressure on m00 holds D1 and stalls input
        drive("t4_h", 8'h00, 1'b0);
        drive("t4_d0", 8'hD0, 1'b0);
        chk_out("t4_d0", 0, 8'hD0, 1'b0);
        drive("t4_d1", 8'hD1, 1'b0);
        chk_out("t4_d1", 0, 8'hD1, 1'b0);
        m00_axis_tready = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = 8'hD2;
        s_axis_tlast    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_rdy", 32'(s_axis_tready), 32'd0);
            chk_out("t4_hold", 0, 8'hD1, 1'b0);
            @(posedge axis_aclk);
            @(negedge axis_aclk);
        end
        m00_axis_tready = 1'b1;
        #1;
        chk("t4_rel_rdy", 32'(s_axis_tready), 32'd1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk_out("t4_d2", 0, 8'hD2, 1'b1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk_out("t4_idle", -1, 8'h00, 1'b0);

        // 5: empty packet, then a normal one
        drive("t5_e", 8'h00, 1'b1);
        chk_out("t5_e", -1, 8'h00, 1'b0);
        chk("t5_drop", 32'(drop_count), 32'd2);
        drive("t5_h", 8'h01, 1'b0);
        chk_out("t5_h", -1, 8'h00, 1'b0);
        drive("t5_e0", 8'hE0, 1'b1);
        chk_out("t5_e0", 1, 8'hE0, 1'b1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk_out("t5_idle", -1, 8'h00, 1'b0);

        // 6: reset while a beat is held in FWD
        drive("t6_h", 8'h00, 1'b0);
        drive("t6_f0", 8'hF0, 1'b0);
        m00_axis_tready = 1'b0;
        #1;
        chk_out("t6_held", 0, 8'hF0, 1'b0);
        axis_aresetn = 1'b0;
        #1;
        chk_out("t6_rst", -1, 8'h00, 1'b0);
        chk("t6_rst_rdy", 32'(s_axis_tready), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        @(negedge axis_aclk);
        axis_aresetn    = 1'b1;
        m00_axis_tready = 1'b1;
        drive("t6_h1", 8'h01, 1'b0);
        chk_out("t6_h1", -1, 8'h00, 1'b0);
        drive("t6_g0", 8'h90, 1'b1);
        chk_out("t6_g0", 1, 8'h90, 1'b1);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk_out("t6_idle", -1, 8'h00, 1'b0);
        chk("t6_drop", 32'(drop_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
